// File: rtl/head_frame_pkg.sv
// Shared constants and types for the PAM head framer and detector.
// The transmit framer imports the same package for its chip and pilot levels.
package head_frame_pkg;

    localparam int              DEF_AD_CVER_WIDTH    = 12;
    localparam int              DEF_FRAME_ADDR_WIDTH = 10;
    localparam int              DEF_PILOT_LEN        = 4;
    localparam int              SEQ_LEN              = 31;
    localparam logic [30:0]     DEF_M_SEQ            = 31'b010_1000_1001_1100_0001_1001_0110_1111;
    localparam logic [11:0]     DEF_SLICE_THRESH     = 12'hBFF;
    localparam logic [4:0]      DEF_CORR_THRESH      = 5'd29;

    localparam logic [11:0]     IDLE_LEVEL           = 12'h080;
    localparam logic [11:0]     CHIP0_LEVEL          = 12'hFFF;
    localparam logic [11:0]     CHIP1_LEVEL          = 12'h7FF;
    localparam logic [11:0]     PILOT_LEVEL          = 12'h400;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        PILOT = 2'd1,
        DATA  = 2'd2
    } head_state_e;

    function automatic logic [4:0] popcount31(input logic [30:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < 31; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/head_frame_detect_sync_correlator.sv
// Hard-decision sliding correlator: slices samples to chips and flags a
// sync header once 31 chips are buffered and enough of them match M_SEQ.
module sync_correlator
    import head_frame_pkg::*;
#(
    parameter int              W            = DEF_AD_CVER_WIDTH,
    parameter logic [W-1:0]    SLICE_THRESH = DEF_SLICE_THRESH,
    parameter logic [30:0]     M_SEQ        = DEF_M_SEQ,
    parameter logic [4:0]      CORR_THRESH  = DEF_CORR_THRESH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            sample_valid,
    input  logic [W-1:0]    sample,
    output logic            sync_hit
);

    logic [30:0] shreg_r;
    logic [4:0]  fill_r;
    logic        chip_s;
    logic [30:0] shreg_next_s;
    logic [4:0]  fill_next_s;
    logic [4:0]  match_s;

    // Match is judged on the register value that includes the current chip.
    always_comb begin
        chip_s       = (sample < SLICE_THRESH);
        shreg_next_s = (shreg_r << 1) | {30'd0, chip_s};
        fill_next_s  = (fill_r == 5'd31) ? 5'd31 : (fill_r + 5'd1);
        match_s      = popcount31(~(shreg_next_s ^ M_SEQ));
        if (sample_valid && (fill_next_s == 5'd31) && (match_s >= CORR_THRESH)) begin
            sync_hit = 1'b1;
        end else begin
            sync_hit = 1'b0;
        end
    end

    // Chip history and saturating fill count.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= 31'd0;
            fill_r  <= 5'd0;
        end else if (clr) begin
            shreg_r <= 31'd0;
            fill_r  <= 5'd0;
        end else if (sample_valid) begin
            shreg_r <= shreg_next_s;
            fill_r  <= fill_next_s;
        end else begin
            shreg_r <= shreg_r;
            fill_r  <= fill_r;
        end
    end

endmodule

// File: rtl/head_frame_detect.sv
// Receive-side frame detector: sync hunt, pilot averaging, payload pairing.
// Optional frame counter is built only when HEAD_DETECT_STATS_EN is defined.
module head_frame_detect
    import head_frame_pkg::*;
#(
    parameter int                          AD_CVER_WIDTH    = DEF_AD_CVER_WIDTH,
    parameter int                          FRAME_ADDR_WIDTH = DEF_FRAME_ADDR_WIDTH,
    parameter logic [AD_CVER_WIDTH-1:0]    SLICE_THRESH     = DEF_SLICE_THRESH,
    parameter logic [30:0]                 M_SEQ            = DEF_M_SEQ,
    parameter logic [4:0]                  CORR_THRESH      = DEF_CORR_THRESH,
    parameter int                          PILOT_LEN        = DEF_PILOT_LEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AD_CVER_WIDTH-1:0]      adc_data,
    input  logic                          adc_valid,
    output logic [2*AD_CVER_WIDTH-1:0]    Head2PamDemap_data,
    output logic                          Head2PamDemap_valid,
    input  logic                          Head2PamDemap_ready,
    output logic                          sync_locked,
    output logic [AD_CVER_WIDTH-1:0]      pilot_avg,
    output logic                          pilot_valid,
    output logic                          overflow,
    output logic [15:0]                   frame_cnt
);

    localparam int PILOT_SHIFT = $clog2(PILOT_LEN);
    localparam int SUM_W       = AD_CVER_WIDTH + PILOT_SHIFT;
    localparam logic [PILOT_SHIFT-1:0]      LAST_PILOT  = PILOT_SHIFT'(PILOT_LEN - 1);
    localparam logic [PILOT_SHIFT-1:0]      PILOT_ONE   = PILOT_SHIFT'(1);
    localparam logic [FRAME_ADDR_WIDTH-1:0] LAST_SAMPLE = {FRAME_ADDR_WIDTH{1'b1}};
    localparam logic [FRAME_ADDR_WIDTH-1:0] DATA_ONE    = FRAME_ADDR_WIDTH'(1);

    head_state_e                  state_r;
    logic [PILOT_SHIFT-1:0]       pilot_cnt_r;
    logic [SUM_W-1:0]             pilot_sum_r;
    logic [FRAME_ADDR_WIDTH-1:0]  data_cnt_r;
    logic [AD_CVER_WIDTH-1:0]     hold_r;

    logic                         hunt_valid_s;
    logic                         frame_end_s;
    logic                         sync_hit_s;
    logic [SUM_W-1:0]             pilot_sum_next_s;

    // Qualify the correlator and detect the last payload sample.
    always_comb begin
        hunt_valid_s     = adc_valid && (state_r == HUNT);
        frame_end_s      = adc_valid && (state_r == DATA) && (data_cnt_r == LAST_SAMPLE);
        pilot_sum_next_s = pilot_sum_r + {{PILOT_SHIFT{1'b0}}, adc_data};
    end

    sync_correlator #(
        .W            (AD_CVER_WIDTH),
        .SLICE_THRESH (SLICE_THRESH),
        .M_SEQ        (M_SEQ),
        .CORR_THRESH  (CORR_THRESH)
    ) u_corr (
        .clk          (clk),
        .rst          (rst),
        .clr          (frame_end_s),
        .sample_valid (hunt_valid_s),
        .sample       (adc_data),
        .sync_hit     (sync_hit_s)
    );

    // Frame FSM with registered outputs; a dropped pair sets the sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= HUNT;
            pilot_cnt_r         <= {PILOT_SHIFT{1'b0}};
            pilot_sum_r         <= {SUM_W{1'b0}};
            data_cnt_r          <= {FRAME_ADDR_WIDTH{1'b0}};
            hold_r              <= {AD_CVER_WIDTH{1'b0}};
            Head2PamDemap_data  <= {(2*AD_CVER_WIDTH){1'b0}};
            Head2PamDemap_valid <= 1'b0;
            sync_locked         <= 1'b0;
            pilot_avg           <= {AD_CVER_WIDTH{1'b0}};
            pilot_valid         <= 1'b0;
            overflow            <= 1'b0;
        end else begin
            Head2PamDemap_valid <= 1'b0;
            pilot_valid         <= 1'b0;
            if (Head2PamDemap_valid && !Head2PamDemap_ready) begin
                overflow <= 1'b1;
            end
            if (adc_valid) begin
                case (state_r)
                    HUNT: begin
                        if (sync_hit_s) begin
                            state_r     <= PILOT;
                            sync_locked <= 1'b1;
                            pilot_cnt_r <= {PILOT_SHIFT{1'b0}};
                            pilot_sum_r <= {SUM_W{1'b0}};
                        end
                    end
                    PILOT: begin
                        if (pilot_cnt_r == LAST_PILOT) begin
                            pilot_avg   <= pilot_sum_next_s[SUM_W-1:PILOT_SHIFT];
                            pilot_valid <= 1'b1;
                            pilot_sum_r <= {SUM_W{1'b0}};
                            pilot_cnt_r <= {PILOT_SHIFT{1'b0}};
                            data_cnt_r  <= {FRAME_ADDR_WIDTH{1'b0}};
                            state_r     <= DATA;
                        end else begin
                            pilot_sum_r <= pilot_sum_next_s;
                            pilot_cnt_r <= pilot_cnt_r + PILOT_ONE;
                        end
                    end
                    DATA: begin
                        data_cnt_r <= data_cnt_r + DATA_ONE;
                        if (!data_cnt_r[0]) begin
                            hold_r <= adc_data;
                        end else begin
                            Head2PamDemap_data  <= {hold_r, adc_data};
                            Head2PamDemap_valid <= 1'b1;
                        end
                        if (data_cnt_r == LAST_SAMPLE) begin
                            state_r     <= HUNT;
                            sync_locked <= 1'b0;
                        end
                    end
                    default: begin
                        state_r     <= HUNT;
                        sync_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef HEAD_DETECT_STATS_EN
    logic [15:0] frame_cnt_r;

    // Completed-frame counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule
